// File: rtl/fabric_reset_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fabric_reset_pkg
// Purpose  : State encoding and shared widths for the fabric reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fabric_reset_pkg;

    localparam int STATE_W = 3;
    localparam int LLC_W   = 8;

    localparam logic [STATE_W-1:0] ST_WAIT_LOCK   = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOCK_STABLE = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT_INIT   = 3'd2;
    localparam logic [STATE_W-1:0] ST_MSS_REL     = 3'd3;
    localparam logic [STATE_W-1:0] ST_FAB_DELAY   = 3'd4;
    localparam logic [STATE_W-1:0] ST_RUN         = 3'd5;
    localparam logic [STATE_W-1:0] ST_SW_RST      = 3'd6;

    // States in which a loss of PLL lock is counted and forces a full restart.
    function automatic logic lock_monitored(input logic [STATE_W-1:0] s);
        return (s >= ST_WAIT_INIT) && (s <= ST_SW_RST);
    endfunction

    function automatic logic mss_released(input logic [STATE_W-1:0] s);
        return (s >= ST_MSS_REL) && (s <= ST_SW_RST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Single-bit two-flop synchronizer with asynchronous active-low clear.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/fabric_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fabric_reset_sequencer
// Purpose  : Sequences MSS and fabric resets from PLL lock and device init done.
// Revision : 1.0 - initial release
// ============================================================================
module fabric_reset_sequencer
    import fabric_reset_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RELEASE_DELAY      = 16,
    parameter int SW_RESET_CYCLES    = 8,
    parameter int CNT_W              = 16
) (
    input  logic               clkin,
    input  logic               resetn,
    input  logic               pll_lock,
    input  logic               init_done,
    input  logic               sw_reset_req,
    output logic               mss_reset_n,
    output logic               fabric_reset_n,
    output logic               ready,
    output logic [STATE_W-1:0] state,
    output logic [LLC_W-1:0]   lock_loss_cnt
);

    localparam logic [CNT_W-1:0] LS_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_DELAY - 1);
    localparam logic [CNT_W-1:0] SW_LAST  = CNT_W'(SW_RESET_CYCLES - 1);

    logic               lock_s;
    logic               init_s;
    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LLC_W-1:0]   llc_q, llc_d;
    logic               mss_q, fab_q, ready_q;

    sync_2ff u_sync_lock (
        .clk_i  (clkin),
        .rst_ni (resetn),
        .d_i    (pll_lock),
        .q_o    (lock_s)
    );

    sync_2ff u_sync_init (
        .clk_i  (clkin),
        .rst_ni (resetn),
        .d_i    (init_done),
        .q_o    (init_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        llc_d   = llc_q;

        case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_LOCK_STABLE;
                    cnt_d   = '0;
                end
            end
            ST_LOCK_STABLE: begin
                if (!lock_s)
                    state_d = ST_WAIT_LOCK;
                else if (cnt_q == LS_LAST)
                    state_d = ST_WAIT_INIT;
                else
                    cnt_d = cnt_q + CNT_W'(1);
            end
            ST_WAIT_INIT: begin
                if (init_s)
                    state_d = ST_MSS_REL;
            end
            ST_MSS_REL: begin
                state_d = ST_FAB_DELAY;
                cnt_d   = '0;
            end
            ST_FAB_DELAY: begin
                if (cnt_q == REL_LAST)
                    state_d = ST_RUN;
                else
                    cnt_d = cnt_q + CNT_W'(1);
            end
            ST_RUN: begin
                if (sw_reset_req) begin
                    state_d = ST_SW_RST;
                    cnt_d   = '0;
                end
            end
            ST_SW_RST: begin
                if (cnt_q == SW_LAST)
                    state_d = ST_RUN;
                else
                    cnt_d = cnt_q + CNT_W'(1);
            end
            default: state_d = ST_WAIT_LOCK;
        endcase

        // Lock loss overrides every other transition once qualification is done.
        if (lock_monitored(state_q) && !lock_s) begin
            state_d = ST_WAIT_LOCK;
            if (llc_q != {LLC_W{1'b1}})
                llc_d = llc_q + LLC_W'(1);
        end
    end

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
            llc_q   <= '0;
            mss_q   <= 1'b0;
            fab_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            llc_q   <= llc_d;
            mss_q   <= mss_released(state_d);
            fab_q   <= (state_d == ST_RUN);
            ready_q <= (state_d == ST_RUN);
        end
    end

    assign mss_reset_n    = mss_q;
    assign fabric_reset_n = fab_q;
    assign ready          = ready_q;
    assign state          = state_q;
    assign lock_loss_cnt  = llc_q;

endmodule
`default_nettype wire
